pixel_bram_unpacker: RTL and testbench
======================================

# pixel_bram_unpacker

Mixed-width pixel buffer for the image-processing datapath.
- Write side: pixels stored one byte at a time.
- Read side: four consecutive pixels fetched as one 32-bit word, split into four byte lanes, and passed through a selectable per-pixel point operation.
- Replaces the separate write/read clock manager, BRAM and byte-splitter with a single-clock block sitting between the external pixel loader and downstream pixel consumers.

## Interface
Parameters:
- BRIGHT_OFS, default 50: saturating brightness offset used by op 2.
- THRESH, default 128: threshold used by op 3.

Ports:
- CLK  in  1: single clock; both RAM ports and all registers run on the rising edge.
- RESET  in  1: reset, asynchronous, active-low.
- ena  in  1: write-port enable.
- wea  in  1: write strobe; a write occurs only when ena=1 and wea=1.
- addra  in  11: byte write address, 0..2047.
- dina  in  8: write pixel.
- enb  in  1: read-port enable.
- addrb  in  9: word read address, 0..511.
- sel_mux  in  2: point-operation select, sampled with addrb.
- out1..out4  out  8 each: processed pixels of the word; out1 is the lowest byte address.

## Operation
- Storage: 2048 x 8 bits, equivalently 512 x 32 bits. Not cleared by reset; power-up content is don't-care.
- Write: when ena & wea, mem byte[addra] <= dina at the clock edge.
- Read mapping: word addrb = bytes 4·addrb+0..+3.
  - Byte +0 goes to lane 1 (bits 7:0), byte +3 to lane 4 (bits 31:24).
  - Little-endian; byte k of the word is byte address 4·addrb+k.
- Stage 1: when enb=1, ram_q <= word[addrb] and sel_q <= sel_mux. When enb=0, ram_q and sel_q hold.
- Stage 2 runs every cycle: outN <= f(byte N of ram_q, sel_q).
- Point operations f(x), all unsigned 8-bit:
  - 0: pass, x.
  - 1: invert, 255 − x.
  - 2: brighten, min(x + BRIGHT_OFS, 255), computed 9-bit then saturated.
  - 3: threshold, (x ≥ THRESH) ? 255 : 0.
- Read/write collision (same cycle, written byte inside the addressed word): read-first. ram_q gets the old byte; the new byte is visible on the next read.
- Addresses are full-range; no wrap or overflow handling is needed.

## Timing
- Reset (RESET=0, asynchronous): ram_q, sel_q and out1..out4 go to 0 immediately and stay 0 while low.
  - RAM contents are preserved.
  - Writes are ignored while RESET=0.
- Write latency: a byte written at edge k is readable by a read sampled at edge k+1 or later.
- Read latency: addrb/sel_mux sampled at edge k (enb=1) give outputs valid after edge k+1, i.e. 2 cycles.
  - Back-to-back reads give one word per cycle.
- With enb=0, outputs keep reflecting the last fetched word and its sel_q, since stage 2 recomputes the same value.
- Reset released mid-read: the pipeline restarts empty. Outputs stay 0 until 2 edges after the first enabled read.
- ena/enb may be high together at any addresses.

## Test plan
- Basic read: write bytes 8,9,10,11 to addra 0..3; read addrb=0, sel=0 -> out1..out4 = 8,9,10,11 two edges later.
- Invert: same word, sel=1 -> 247,246,245,244.
- Brighten: bytes 0,100,205,220 at addra 4..7; read addrb=1, sel=2 -> 50,150,255,255.
- Threshold: bytes 0,127,128,255 at addra 8..11; read addrb=2, sel=3 -> 0,0,255,255.
- Pipeline/sel alignment: reads of addrb 0,1,2 with sel 0,1,2 on consecutive cycles -> each output word processed with its own sel. Drop enb -> outputs hold.
- Collision and reset:
  - Write 77 to addra 0 in the same cycle as a read of addrb=0 -> out1 = old value 8; the next read gives 77.
  - Pulse RESET low mid-stream -> outputs 0 at once; after release, rereading addrb=0 returns 77, proving RAM contents were kept.

Source files
------------

// File: rtl/pixel_bram_unpacker_if.sv
// Pixel buffer bus: byte-wide write port from the pixel loader, word-wide
// read request plus four processed pixel lanes back to the consumers.
interface pixel_bram_unpacker_if;
   logic       ena;
   logic       wea;
   logic [10:0] addra;
   logic [7:0] dina;
   logic       enb;
   logic [8:0] addrb;
   logic [1:0] sel_mux;
   logic [7:0] out1;
   logic [7:0] out2;
   logic [7:0] out3;
   logic [7:0] out4;

   // Loader/consumer side drives requests and receives pixels.
   modport master (
      output ena, wea, addra, dina, enb, addrb, sel_mux,
      input  out1, out2, out3, out4
   );

   // Buffer side.
   modport slave (
      input  ena, wea, addra, dina, enb, addrb, sel_mux,
      output out1, out2, out3, out4
   );
endinterface

// File: rtl/pixel_bram_unpacker.sv
// Single-clock mixed-width pixel buffer. Pixels are written one byte at a
// time and read back four at a time as a little-endian 32-bit word, then each
// byte lane goes through a selectable point operation. Two-stage read:
// RAM word register (stage 1) and point-operation register (stage 2).
module pixel_bram_unpacker #(
   parameter int BRIGHT_OFS = 50,
   parameter int THRESH     = 128
) (
   input logic                  CLK,
   input logic                  RESET,
   pixel_bram_unpacker_if.slave bus
);

   localparam logic [8:0] OFS9 = 9'(BRIGHT_OFS);
   localparam logic [8:0] THR9 = 9'(THRESH);

   localparam logic [1:0] OP_PASS   = 2'd0;
   localparam logic [1:0] OP_INVERT = 2'd1;
   localparam logic [1:0] OP_BRIGHT = 2'd2;
   localparam logic [1:0] OP_THRESH = 2'd3;

   // 512 words of four byte lanes; lane k of word w is byte address 4*w+k.
   logic [3:0][7:0] mem [0:511];

   logic            wr_en;
   logic [3:0][7:0] ram_q;
   logic [1:0]      sel_q;
   logic [3:0][7:0] lane_res;

   // Unsigned 8-bit point operation applied to one pixel.
   function automatic logic [7:0] point_op(input logic [7:0] x, input logic [1:0] sel);
      logic [8:0] sum;
      logic [7:0] res;
      sum = {1'b0, x} + OFS9;
      res = x;
      case (sel)
         OP_PASS:   res = x;
         OP_INVERT: res = 8'hFF - x;
         OP_BRIGHT: res = sum[8] ? 8'hFF : sum[7:0];
         OP_THRESH: res = ({1'b0, x} >= THR9) ? 8'hFF : 8'h00;
         default:   res = x;
      endcase
      return res;
   endfunction

   // Writes are blocked while reset is held so the RAM keeps its contents.
   assign wr_en = bus.ena & bus.wea & RESET;

   // Byte-lane write port; RAM content is never cleared.
   always_ff @(posedge CLK) begin
      if (wr_en) begin
         mem[bus.addra[10:2]][bus.addra[1:0]] <= bus.dina;
      end
   end

   // Stage 1: read-first word fetch with the operation select captured alongside.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         ram_q <= '0;
         sel_q <= '0;
      end else if (bus.enb) begin
         ram_q <= mem[bus.addrb];
         sel_q <= bus.sel_mux;
      end
   end

   // Per-lane point operation on the fetched word.
   always_comb begin
      lane_res = '0;
      for (int i = 0; i < 4; i++) begin
         lane_res[i] = point_op(ram_q[i], sel_q);
      end
   end

   // Stage 2: recomputed every cycle, so outputs hold while stage 1 holds.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         bus.out1 <= '0;
         bus.out2 <= '0;
         bus.out3 <= '0;
         bus.out4 <= '0;
      end else begin
         bus.out1 <= lane_res[0];
         bus.out2 <= lane_res[1];
         bus.out3 <= lane_res[2];
         bus.out4 <= lane_res[3];
      end
   end

endmodule

// File: tb/tb_pixel_bram_unpacker.sv
// Directed bench for pixel_bram_unpacker: writes, reads with each point
// operation, pipelined reads, hold, read/write collision and async reset.
module tb_pixel_bram_unpacker;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   pixel_bram_unpacker_if bus();

   pixel_bram_unpacker #(
      .BRIGHT_OFS(50),
      .THRESH    (128)
   ) dut (
      .CLK  (clk),
      .RESET(rst_n),
      .bus  (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance one rising edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr_byte(input logic [10:0] a, input logic [7:0] d);
      bus.ena   = 1'b1;
      bus.wea   = 1'b1;
      bus.addra = a;
      bus.dina  = d;
      tick();
      bus.ena   = 1'b0;
      bus.wea   = 1'b0;
   endtask

   // Issue a single read and wait for its result (two edges).
   task automatic rd_word(input logic [8:0] a, input logic [1:0] sel);
      bus.enb     = 1'b1;
      bus.addrb   = a;
      bus.sel_mux = sel;
      tick();
      bus.enb     = 1'b0;
      tick();
   endtask

   function automatic logic [31:0] outs();
      return {bus.out1, bus.out2, bus.out3, bus.out4};
   endfunction

   task automatic test_reset();
      bus.ena = 0; bus.wea = 0; bus.addra = '0; bus.dina = '0;
      bus.enb = 0; bus.addrb = '0; bus.sel_mux = '0;
      rst_n = 1'b1;
      #3 rst_n = 1'b0;
      tick();
      tick();
      checks++;
      if (outs() !== 32'h0) begin
         errors++;
         $display("FAIL reset_outs got=%h exp=%h", outs(), 32'h0);
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      wr_byte(11'd0, 8'd8);
      wr_byte(11'd1, 8'd9);
      wr_byte(11'd2, 8'd10);
      wr_byte(11'd3, 8'd11);
      bus.enb = 1'b1; bus.addrb = 9'd0; bus.sel_mux = 2'd0;
      tick();
      bus.enb = 1'b0;
      checks++;
      if (outs() !== 32'h0) begin
         errors++;
         $display("FAIL basic_latency_1edge got=%h exp=%h", outs(), 32'h0);
      end
      tick();
      checks++;
      if (outs() !== {8'd8, 8'd9, 8'd10, 8'd11}) begin
         errors++;
         $display("FAIL basic_pass got=%h exp=%h", outs(), {8'd8, 8'd9, 8'd10, 8'd11});
      end
   endtask

   task automatic test_invert();
      rd_word(9'd0, 2'd1);
      checks++;
      if (outs() !== {8'd247, 8'd246, 8'd245, 8'd244}) begin
         errors++;
         $display("FAIL invert got=%h exp=%h", outs(), {8'd247, 8'd246, 8'd245, 8'd244});
      end
   endtask

   task automatic test_brighten();
      wr_byte(11'd4, 8'd0);
      wr_byte(11'd5, 8'd100);
      wr_byte(11'd6, 8'd205);
      wr_byte(11'd7, 8'd220);
      rd_word(9'd1, 2'd2);
      checks++;
      if (outs() !== {8'd50, 8'd150, 8'd255, 8'd255}) begin
         errors++;
         $display("FAIL brighten got=%h exp=%h", outs(), {8'd50, 8'd150, 8'd255, 8'd255});
      end
   endtask

   task automatic test_threshold();
      wr_byte(11'd8, 8'd0);
      wr_byte(11'd9, 8'd127);
      wr_byte(11'd10, 8'd128);
      wr_byte(11'd11, 8'd255);
      rd_word(9'd2, 2'd3);
      checks++;
      if (outs() !== {8'd0, 8'd0, 8'd255, 8'd255}) begin
         errors++;
         $display("FAIL threshold got=%h exp=%h", outs(), {8'd0, 8'd0, 8'd255, 8'd255});
      end
   endtask

   // Read issued on the edge right after the last write must see it.
   task automatic test_write_latency();
      wr_byte(11'd12, 8'd1);
      wr_byte(11'd13, 8'd2);
      wr_byte(11'd14, 8'd3);
      wr_byte(11'd15, 8'd200);
      rd_word(9'd3, 2'd0);
      checks++;
      if (outs() !== {8'd1, 8'd2, 8'd3, 8'd200}) begin
         errors++;
         $display("FAIL write_then_read got=%h exp=%h", outs(), {8'd1, 8'd2, 8'd3, 8'd200});
      end
   endtask

   task automatic test_back_to_back();
      bus.enb = 1'b1; bus.addrb = 9'd0; bus.sel_mux = 2'd0;
      tick();
      bus.addrb = 9'd1; bus.sel_mux = 2'd1;
      tick();
      checks++;
      if (outs() !== {8'd8, 8'd9, 8'd10, 8'd11}) begin
         errors++;
         $display("FAIL b2b_word0_pass got=%h exp=%h", outs(), {8'd8, 8'd9, 8'd10, 8'd11});
      end
      bus.addrb = 9'd2; bus.sel_mux = 2'd2;
      tick();
      checks++;
      if (outs() !== {8'd255, 8'd155, 8'd50, 8'd35}) begin
         errors++;
         $display("FAIL b2b_word1_invert got=%h exp=%h", outs(), {8'd255, 8'd155, 8'd50, 8'd35});
      end
      bus.enb = 1'b0; bus.addrb = 9'd0; bus.sel_mux = 2'd3;
      tick();
      checks++;
      if (outs() !== {8'd50, 8'd177, 8'd178, 8'd255}) begin
         errors++;
         $display("FAIL b2b_word2_bright got=%h exp=%h", outs(), {8'd50, 8'd177, 8'd178, 8'd255});
      end
      tick();
      tick();
      checks++;
      if (outs() !== {8'd50, 8'd177, 8'd178, 8'd255}) begin
         errors++;
         $display("FAIL hold_enb_low got=%h exp=%h", outs(), {8'd50, 8'd177, 8'd178, 8'd255});
      end
   endtask

   task automatic test_collision();
      bus.ena = 1'b1; bus.wea = 1'b1; bus.addra = 11'd0; bus.dina = 8'd77;
      bus.enb = 1'b1; bus.addrb = 9'd0; bus.sel_mux = 2'd0;
      tick();
      bus.ena = 1'b0; bus.wea = 1'b0; bus.enb = 1'b0;
      tick();
      checks++;
      if (outs() !== {8'd8, 8'd9, 8'd10, 8'd11}) begin
         errors++;
         $display("FAIL collision_read_first got=%h exp=%h", outs(), {8'd8, 8'd9, 8'd10, 8'd11});
      end
      rd_word(9'd0, 2'd0);
      checks++;
      if (outs() !== {8'd77, 8'd9, 8'd10, 8'd11}) begin
         errors++;
         $display("FAIL collision_new_visible got=%h exp=%h", outs(), {8'd77, 8'd9, 8'd10, 8'd11});
      end
   endtask

   task automatic test_reset_midstream();
      bus.enb = 1'b1; bus.addrb = 9'd3; bus.sel_mux = 2'd1;
      tick();
      bus.enb = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (outs() !== 32'h0) begin
         errors++;
         $display("FAIL reset_async_clear got=%h exp=%h", outs(), 32'h0);
      end
      bus.ena = 1'b1; bus.wea = 1'b1; bus.addra = 11'd0; bus.dina = 8'd99;
      tick();
      bus.ena = 1'b0; bus.wea = 1'b0;
      tick();
      checks++;
      if (outs() !== 32'h0) begin
         errors++;
         $display("FAIL reset_held_low got=%h exp=%h", outs(), 32'h0);
      end
      #2 rst_n = 1'b1;
      tick();
      checks++;
      if (outs() !== 32'h0) begin
         errors++;
         $display("FAIL reset_pipeline_empty got=%h exp=%h", outs(), 32'h0);
      end
      bus.enb = 1'b1; bus.addrb = 9'd0; bus.sel_mux = 2'd0;
      tick();
      bus.enb = 1'b0;
      checks++;
      if (outs() !== 32'h0) begin
         errors++;
         $display("FAIL reset_first_read_1edge got=%h exp=%h", outs(), 32'h0);
      end
      tick();
      checks++;
      if (outs() !== {8'd77, 8'd9, 8'd10, 8'd11}) begin
         errors++;
         $display("FAIL reset_ram_kept got=%h exp=%h", outs(), {8'd77, 8'd9, 8'd10, 8'd11});
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_basic();
      test_invert();
      test_brighten();
      test_threshold();
      test_write_latency();
      test_back_to_back();
      test_collision();
      test_reset_midstream();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
